ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder.sv | 149 ++++++++++++++
 tb/tb_ps2_key_decoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into {ext,brk,code} events,
// tracks modifier and caps-lock state, and queues events in a small FIFO.
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_byte_code,
  input  logic       i_update_key,
  input  logic       i_ack,
  input  logic       i_clr_ovf,
  output logic       o_valid,
  output logic [9:0] o_event,
  output logic       o_shift,
  output logic       o_ctrl,
  output logic       o_alt,
  output logic       o_caps,
  output logic       o_kbd_err,
  output logic       o_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic [9:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      head_q, head_d;
  logic            shift_q, shift_d, ctrl_q, ctrl_d, alt_q, alt_d;
  logic            caps_q, caps_d, held_q, held_d;
  logic            err_q, ovf_q, ovf_d;

  logic            is_e0, is_f0, is_err, is_ctl, push_req;
  logic            ext, brk, full, pop, do_push, drop;
  logic [9:0]      evt;

  always_comb begin
    is_e0    = (i_byte_code == 8'hE0);
    is_f0    = (i_byte_code == 8'hF0);
    is_err   = (i_byte_code == 8'h00) || (i_byte_code == 8'hFF);
    is_ctl   = (i_byte_code == 8'hAA) || (i_byte_code == 8'hFA) ||
               (i_byte_code == 8'hEE) || (i_byte_code == 8'hFE);
    push_req = i_update_key && !(is_e0 || is_f0 || is_err || is_ctl);
    ext      = (state_q == S_EXT) || (state_q == S_EXT_BRK);
    brk      = (state_q == S_BRK) || (state_q == S_EXT_BRK);
    evt      = {ext, brk, i_byte_code};
    full     = (count_q == CW'(FIFO_DEPTH));
    pop      = i_ack && (count_q != '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push  = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  always_comb begin
    state_d = state_q;
    if (i_update_key) begin
      if (is_e0) begin
        if (state_q == S_IDLE)     state_d = S_EXT;
        else if (state_q == S_BRK) state_d = S_EXT_BRK;
      end else if (is_f0) begin
        if (state_q == S_IDLE)     state_d = S_BRK;
        else if (state_q == S_EXT) state_d = S_EXT_BRK;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    shift_d = shift_q;
    ctrl_d  = ctrl_q;
    alt_d   = alt_q;
    caps_d  = caps_q;
    held_d  = held_q;
    if (push_req) begin
      if (!ext && (i_byte_code == 8'h12 || i_byte_code == 8'h59)) shift_d = !brk;
      if (i_byte_code == 8'h14) ctrl_d = !brk;
      if (i_byte_code == 8'h11) alt_d  = !brk;
      // caps_held suppresses toggling on typematic repeats of the caps make.
      if (!ext && i_byte_code == 8'h58) begin
        if (brk) begin
          held_d = 1'b0;
        end else if (!held_q) begin
          caps_d = !caps_q;
          held_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(pop);
    ovf_d    = drop ? 1'b1 : (i_clr_ovf ? 1'b0 : ovf_q);
    head_d   = head_q;
    // The next head is the entry being written when it lands at the new read slot.
    if (count_d != '0) begin
      head_d = (do_push && wr_ptr_q == rd_ptr_d) ? evt : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= evt;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
      shift_q  <= 1'b0;
      ctrl_q   <= 1'b0;
      alt_q    <= 1'b0;
      caps_q   <= 1'b0;
      held_q   <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
      shift_q  <= shift_d;
      ctrl_q   <= ctrl_d;
      alt_q    <= alt_d;
      caps_q   <= caps_d;
      held_q   <= held_d;
      err_q    <= i_update_key && is_err;
      ovf_q    <= ovf_d;
    end
  end

  assign o_valid    = (count_q != '0);
  assign o_event    = head_q;
  assign o_shift    = shift_q;
  assign o_ctrl     = ctrl_q;
  assign o_alt      = alt_q;
  assign o_caps     = caps_q;
  assign o_kbd_err  = err_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: vector table plus hand sequences, events checked
// against a scoreboard queue as they are acknowledged out of the FIFO.
module tb_ps2_key_decoder;

  localparam int FIFO_DEPTH = 4;

  logic       clk = 1'b0;
  logic       i_rst, i_update_key, i_ack, i_clr_ovf;
  logic [7:0] i_byte_code;
  logic       o_valid, o_shift, o_ctrl, o_alt, o_caps, o_kbd_err, o_overflow;
  logic [9:0] o_event;

  ps2_key_decoder #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_byte_code(i_byte_code),
    .i_update_key(i_update_key), .i_ack(i_ack), .i_clr_ovf(i_clr_ovf),
    .o_valid(o_valid), .o_event(o_event), .o_shift(o_shift), .o_ctrl(o_ctrl),
    .o_alt(o_alt), .o_caps(o_caps), .o_kbd_err(o_kbd_err), .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       push;
    logic [9:0] ev;
    logic       drain;
  } vec_t;

  vec_t       tbl [18];
  logic [9:0] sb [$];
  int         n_cmp = 0;
  int         n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic push, input logic [9:0] ev);
    i_byte_code  = b;
    i_update_key = 1'b1;
    if (push) sb.push_back(ev);
    step();
    i_update_key = 1'b0;
  endtask

  task automatic drain();
    int         guard = 0;
    logic [9:0] exp;
    while (o_valid && guard < 2 * FIFO_DEPTH + 2) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL drain_extra: got %0h required none", o_event);
      end else begin
        exp = sb.pop_front();
        chk("drain_event", 32'(o_event), 32'(exp));
      end
      i_ack = 1'b1;
      step();
      i_ack = 1'b0;
      guard++;
    end
    chk("drain_valid", 32'(o_valid), 32'd0);
    chk("drain_sb_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [9:0] exp;
    tbl[0]  = '{8'h1C, 1'b1, 10'h01C, 1'b0};
    tbl[1]  = '{8'hE0, 1'b0, 10'h000, 1'b0};
    tbl[2]  = '{8'hF0, 1'b0, 10'h000, 1'b0};
    tbl[3]  = '{8'h75, 1'b1, 10'h375, 1'b0};
    tbl[4]  = '{8'hE0, 1'b0, 10'h000, 1'b0};
    tbl[5]  = '{8'h6B, 1'b1, 10'h26B, 1'b0};
    tbl[6]  = '{8'hF0, 1'b0, 10'h000, 1'b0};
    tbl[7]  = '{8'h1C, 1'b1, 10'h11C, 1'b1};
    tbl[8]  = '{8'hE0, 1'b0, 10'h000, 1'b0};
    tbl[9]  = '{8'hAA, 1'b0, 10'h000, 1'b0};
    tbl[10] = '{8'h1C, 1'b1, 10'h01C, 1'b0};
    tbl[11] = '{8'hF0, 1'b0, 10'h000, 1'b0};
    tbl[12] = '{8'hFE, 1'b0, 10'h000, 1'b0};
    tbl[13] = '{8'h1C, 1'b1, 10'h01C, 1'b0};
    tbl[14] = '{8'hE0, 1'b0, 10'h000, 1'b0};
    tbl[15] = '{8'hF0, 1'b0, 10'h000, 1'b0};
    tbl[16] = '{8'hEE, 1'b0, 10'h000, 1'b0};
    tbl[17] = '{8'h5A, 1'b1, 10'h05A, 1'b1};

    i_rst = 1'b1; i_update_key = 1'b0; i_ack = 1'b0; i_clr_ovf = 1'b0; i_byte_code = 8'h00;
    step(); step();
    i_rst = 1'b0;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_event", 32'(o_event), 32'd0);
    chk("rst_mods", 32'({o_shift, o_ctrl, o_alt, o_caps}), 32'd0);
    chk("rst_err_ovf", 32'({o_kbd_err, o_overflow}), 32'd0);

    for (int i = 0; i < 18; i++) begin
      send(tbl[i].b, tbl[i].push, tbl[i].ev);
      chk("vec_valid", 32'(o_valid), 32'(sb.size() != 0));
      chk("vec_err", 32'(o_kbd_err), 32'd0);
      if (tbl[i].drain) drain();
    end

    // Shift / ctrl / alt
    send(8'h12, 1'b1, 10'h012);
    chk("shift_make", 32'(o_shift), 32'd1);
    send(8'h1C, 1'b1, 10'h01C);
    send(8'hF0, 1'b0, 10'h000);
    chk("shift_after_f0", 32'(o_shift), 32'd1);
    send(8'h12, 1'b1, 10'h112);
    chk("shift_break", 32'(o_shift), 32'd0);
    drain();
    send(8'hE0, 1'b0, 10'h000);
    send(8'h14, 1'b1, 10'h214);
    chk("ctrl_ext_make", 32'(o_ctrl), 32'd1);
    send(8'hF0, 1'b0, 10'h000);
    send(8'h14, 1'b1, 10'h114);
    chk("ctrl_break", 32'(o_ctrl), 32'd0);
    send(8'hE0, 1'b0, 10'h000);
    send(8'h12, 1'b1, 10'h212);
    chk("shift_ext_ignored", 32'(o_shift), 32'd0);
    drain();
    send(8'hE0, 1'b0, 10'h000);
    send(8'h11, 1'b1, 10'h211);
    chk("alt_make", 32'(o_alt), 32'd1);
    send(8'hF0, 1'b0, 10'h000);
    send(8'h11, 1'b1, 10'h111);
    chk("alt_break", 32'(o_alt), 32'd0);
    drain();

    // Caps lock with typematic repeats
    send(8'h58, 1'b1, 10'h058);
    chk("caps_first", 32'(o_caps), 32'd1);
    send(8'h58, 1'b1, 10'h058);
    send(8'h58, 1'b1, 10'h058);
    chk("caps_repeat", 32'(o_caps), 32'd1);
    drain();
    send(8'hF0, 1'b0, 10'h000);
    send(8'h58, 1'b1, 10'h158);
    chk("caps_break", 32'(o_caps), 32'd1);
    send(8'h58, 1'b1, 10'h058);
    chk("caps_second", 32'(o_caps), 32'd0);
    send(8'h58, 1'b1, 10'h058);
    chk("caps_second_rep", 32'(o_caps), 32'd0);
    send(8'hF0, 1'b0, 10'h000);
    send(8'h58, 1'b1, 10'h158);
    drain();

    // Overflow, push+pop when full, clear
    send(8'h15, 1'b1, 10'h015);
    send(8'h1D, 1'b1, 10'h01D);
    send(8'h24, 1'b1, 10'h024);
    send(8'h2D, 1'b1, 10'h02D);
    chk("ovf_not_yet", 32'(o_overflow), 32'd0);
    send(8'h2C, 1'b0, 10'h000);
    chk("ovf_set", 32'(o_overflow), 32'd1);
    exp = sb.pop_front();
    chk("ovf_head", 32'(o_event), 32'(exp));
    i_ack = 1'b1;
    send(8'h35, 1'b1, 10'h035);
    i_ack = 1'b0;
    chk("pushpop_full_ovf", 32'(o_overflow), 32'd1);
    chk("pushpop_full_head", 32'(o_event), 32'h01D);
    i_clr_ovf = 1'b1;
    send(8'h3C, 1'b0, 10'h000);
    i_clr_ovf = 1'b0;
    chk("drop_beats_clr", 32'(o_overflow), 32'd1);
    i_clr_ovf = 1'b1;
    step();
    i_clr_ovf = 1'b0;
    chk("ovf_clr", 32'(o_overflow), 32'd0);
    drain();

    // Ack while empty is ignored
    i_ack = 1'b1;
    step();
    i_ack = 1'b0;
    chk("ack_empty", 32'(o_valid), 32'd0);
    send(8'h1C, 1'b1, 10'h01C);
    chk("after_ack_empty", 32'(o_event), 32'h01C);
    drain();

    // Keyboard error bytes
    send(8'hE0, 1'b0, 10'h000);
    send(8'h00, 1'b0, 10'h000);
    chk("err_pulse", 32'(o_kbd_err), 32'd1);
    chk("err_no_event", 32'(o_valid), 32'd0);
    step();
    chk("err_one_cycle", 32'(o_kbd_err), 32'd0);
    send(8'h1C, 1'b1, 10'h01C);
    drain();
    send(8'hF0, 1'b0, 10'h000);
    send(8'hFF, 1'b0, 10'h000);
    chk("err_ff", 32'(o_kbd_err), 32'd1);
    send(8'h1C, 1'b1, 10'h01C);
    chk("err_ff_end", 32'(o_kbd_err), 32'd0);
    drain();

    // Reset mid-prefix with competing inputs
    send(8'h12, 1'b1, 10'h012);
    send(8'h58, 1'b1, 10'h058);
    chk("pre_rst_mods", 32'({o_shift, o_caps}), 32'd3);
    send(8'hE0, 1'b0, 10'h000);
    send(8'hF0, 1'b0, 10'h000);
    i_rst = 1'b1; i_update_key = 1'b1; i_byte_code = 8'h1C; i_ack = 1'b1; i_clr_ovf = 1'b1;
    step();
    i_rst = 1'b0; i_update_key = 1'b0; i_ack = 1'b0; i_clr_ovf = 1'b0;
    sb.delete();
    chk("rst2_valid", 32'(o_valid), 32'd0);
    chk("rst2_event", 32'(o_event), 32'd0);
    chk("rst2_mods", 32'({o_shift, o_ctrl, o_alt, o_caps}), 32'd0);
    send(8'h1C, 1'b1, 10'h01C);
    chk("rst2_prefix_gone", 32'(o_event), 32'h01C);
    send(8'h58, 1'b1, 10'h058);
    chk("rst2_caps_held_clr", 32'(o_caps), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
